// File: rtl/simon_sequence_player_if.sv
// Bundles the control, pattern-RAM and timer signals of the Simon sequence
// player. "slave" is the player's view; "master" is the surrounding logic
// (game control, pattern RAM, timer).
interface simon_sequence_player_if #(
    parameter int MAX_LEN = 16,
    parameter int COLOR_W = 2
);
    localparam int IDX_W   = $clog2(MAX_LEN);
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int NUM_LED = 2 ** COLOR_W;

    logic               play;
    logic               abort;
    logic [LEN_W-1:0]   seq_len;
    logic [IDX_W-1:0]   rd_addr;
    logic [COLOR_W-1:0] rd_data;
    logic               start_timer;
    logic               timer_done;
    logic [NUM_LED-1:0] led;
    logic               busy;
    logic               done;

    modport slave (
        input  play, abort, seq_len, rd_data, timer_done,
        output rd_addr, start_timer, led, busy, done
    );

    modport master (
        output play, abort, seq_len, rd_data, timer_done,
        input  rd_addr, start_timer, led, busy, done
    );
endinterface

// File: rtl/simon_sequence_player.sv
// Simon sequence player: walks the stored pattern, lighting one LED per step
// for a timed on-phase followed by a timed all-off gap, using an external
// timer that it reloads with start_timer and watches through timer_done.
module simon_sequence_player #(
    parameter int MAX_LEN = 16,
    parameter int COLOR_W = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    simon_sequence_player_if.slave bus
);
    localparam int IDX_W   = $clog2(MAX_LEN);
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int NUM_LED = 2 ** COLOR_W;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ON_START,
        ON_WAIT,
        OFF_START,
        OFF_WAIT,
        FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [NUM_LED-1:0] led_q, led_d;

    // Requested length clamped to the pattern RAM depth.
    logic [LEN_W-1:0]   len_clamped;
    logic               last_step;

    assign len_clamped = (bus.seq_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.seq_len;
    assign last_step   = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            led_q   <= led_d;
        end
    end

    // Next-state logic; abort overrides everything and returns to IDLE cleanly.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        led_d   = led_q;
        if (bus.abort) begin
            state_d = IDLE;
            idx_d   = '0;
            led_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.play) begin
                        len_d   = len_clamped;
                        idx_d   = '0;
                        state_d = (len_clamped == '0) ? FINISH : FETCH;
                    end
                end
                FETCH:     state_d = ON_START;
                ON_START: begin
                    // RAM data for idx_q is valid here (address was held through FETCH).
                    led_d   = NUM_LED'(1) << bus.rd_data;
                    state_d = ON_WAIT;
                end
                ON_WAIT: begin
                    if (bus.timer_done) begin
                        led_d   = '0;
                        state_d = OFF_START;
                    end
                end
                OFF_START: state_d = OFF_WAIT;
                OFF_WAIT: begin
                    if (bus.timer_done) begin
                        if (last_step) begin
                            state_d = FINISH;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = FETCH;
                        end
                    end
                end
                FINISH:    state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Outputs come only from registers or from the state decode.
    assign bus.rd_addr     = idx_q;
    assign bus.led         = led_q;
    assign bus.start_timer = (state_q == ON_START) || (state_q == OFF_START);
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == FINISH);
endmodule

// File: tb/tb_simon_sequence_player.sv
// Bench for simon_sequence_player: pattern RAM model, 3-cycle timer stub,
// an output monitor that logs LED changes and start_timer addresses, and
// scenario tasks that push expected values and compare against the logs.
module tb_simon_sequence_player;
    localparam int MAX_LEN = 16;
    localparam int COLOR_W = 2;
    localparam int NUM_LED = 4;

    logic clk = 0;
    logic reset_n = 0;
    always #5 clk = ~clk;

    simon_sequence_player_if #(.MAX_LEN(MAX_LEN), .COLOR_W(COLOR_W)) bus ();

    simon_sequence_player #(.MAX_LEN(MAX_LEN), .COLOR_W(COLOR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Pattern RAM model: synchronous read.
    logic [COLOR_W-1:0] mem [MAX_LEN];
    always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

    // Timer stub: done drops the cycle after start, rises 3 cycles later.
    logic [1:0] tcnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)             tcnt <= 2'd0;
        else if (bus.start_timer) tcnt <= 2'd3;
        else if (tcnt != 2'd0)    tcnt <= tcnt - 2'd1;
    end
    assign bus.timer_done = (tcnt == 2'd0);

    // Monitor, sampling away from the active edge.
    logic [NUM_LED-1:0] act_led[$];
    logic [3:0]         act_addr[$];
    logic [NUM_LED-1:0] led_prev = '0;
    logic               prev_start = 1'b0;
    int                 start_cnt = 0;
    int                 done_cnt = 0;
    int                 dbl_cnt = 0;
    always @(negedge clk) begin
        if (bus.led !== led_prev) act_led.push_back(bus.led);
        led_prev <= bus.led;
        if (bus.start_timer) begin
            act_addr.push_back(bus.rd_addr);
            start_cnt <= start_cnt + 1;
            if (prev_start) dbl_cnt <= dbl_cnt + 1;
        end
        prev_start <= bus.start_timer;
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    // Scoreboard of expectations.
    logic [NUM_LED-1:0] exp_led[$];
    logic [3:0]         exp_addr[$];
    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic push_step(input int idx, input int colour);
        exp_led.push_back(NUM_LED'(1 << colour));
        exp_led.push_back('0);
        exp_addr.push_back(4'(idx));
        exp_addr.push_back(4'(idx));
    endtask

    task automatic do_play(input int len);
        @(negedge clk);
        bus.seq_len = 5'(len);
        bus.play    = 1'b1;
        @(negedge clk);
        bus.play    = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input int bd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done_cnt > bd && !bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_starts(input int target, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (start_cnt == target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #1;
        total_cnt++; if (bus.led !== 4'b0) $display("FAIL reset_led: got %b want 0000", bus.led); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.start_timer !== 1'b0) $display("FAIL reset_start: got %b want 0", bus.start_timer); else pass_cnt++;
        total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else pass_cnt++;
        total_cnt++; if (bus.rd_addr !== 4'd0) $display("FAIL reset_addr: got %0d want 0", bus.rd_addr); else pass_cnt++;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL idle_after_reset: busy got %b want 0", bus.busy); else pass_cnt++;
    endtask

    task automatic test_basic;
        int bs, bd, bl, ba;
        bit ok;
        logic [NUM_LED-1:0] el;
        logic [3:0] ea;
        mem[0] = 2; mem[1] = 0; mem[2] = 3;
        bs = start_cnt; bd = done_cnt; bl = act_led.size(); ba = act_addr.size();
        for (int i = 0; i < 3; i++) push_step(i, int'(mem[i]));
        do_play(3);
        wait_idle(500, bd, ok);
        total_cnt++; if (!ok) $display("FAIL basic_timeout: got busy=%b want idle+done", bus.busy); else pass_cnt++;
        total_cnt++; if (start_cnt - bs !== 6) $display("FAIL basic_starts: got %0d want 6", start_cnt - bs); else pass_cnt++;
        total_cnt++; if (done_cnt - bd !== 1) $display("FAIL basic_done: got %0d want 1", done_cnt - bd); else pass_cnt++;
        total_cnt++; if (act_led.size() - bl !== exp_led.size()) $display("FAIL basic_led_count: got %0d want %0d", act_led.size() - bl, exp_led.size()); else pass_cnt++;
        while (exp_led.size() > 0) begin
            el = exp_led.pop_front();
            total_cnt++;
            if (bl >= act_led.size() || act_led[bl] !== el) $display("FAIL basic_led[%0d]: got %b want %b", bl, (bl < act_led.size()) ? act_led[bl] : 4'bx, el); else pass_cnt++;
            bl++;
        end
        while (exp_addr.size() > 0) begin
            ea = exp_addr.pop_front();
            total_cnt++;
            if (ba >= act_addr.size() || act_addr[ba] !== ea) $display("FAIL basic_addr[%0d]: got %0d want %0d", ba, (ba < act_addr.size()) ? act_addr[ba] : 4'bx, ea); else pass_cnt++;
            ba++;
        end
    endtask

    task automatic test_zero_len;
        int bs, bd;
        bs = start_cnt; bd = done_cnt;
        do_play(0);
        total_cnt++; if (bus.done !== 1'b1) $display("FAIL zero_done: got %b want 1", bus.done); else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++; if (done_cnt - bd !== 1) $display("FAIL zero_done_count: got %0d want 1", done_cnt - bd); else pass_cnt++;
        total_cnt++; if (start_cnt !== bs) $display("FAIL zero_starts: got %0d want 0", start_cnt - bs); else pass_cnt++;
        total_cnt++; if (bus.led !== 4'b0 || bus.busy !== 1'b0) $display("FAIL zero_idle: got led=%b busy=%b want 0000/0", bus.led, bus.busy); else pass_cnt++;
    endtask

    task automatic test_clamp;
        int bs, bd, bl, ba;
        bit ok;
        logic [NUM_LED-1:0] el;
        logic [3:0] ea;
        for (int i = 0; i < MAX_LEN; i++) mem[i] = COLOR_W'(i % 4);
        bs = start_cnt; bd = done_cnt; bl = act_led.size(); ba = act_addr.size();
        for (int i = 0; i < MAX_LEN; i++) push_step(i, i % 4);
        do_play(20);
        wait_idle(2000, bd, ok);
        total_cnt++; if (!ok) $display("FAIL clamp_timeout: got busy=%b want idle+done", bus.busy); else pass_cnt++;
        total_cnt++; if (start_cnt - bs !== 32) $display("FAIL clamp_starts: got %0d want 32", start_cnt - bs); else pass_cnt++;
        total_cnt++; if (dbl_cnt !== 0) $display("FAIL start_double: got %0d want 0", dbl_cnt); else pass_cnt++;
        while (exp_led.size() > 0) begin
            el = exp_led.pop_front();
            total_cnt++;
            if (bl >= act_led.size() || act_led[bl] !== el) $display("FAIL clamp_led[%0d]: got %b want %b", bl, (bl < act_led.size()) ? act_led[bl] : 4'bx, el); else pass_cnt++;
            bl++;
        end
        while (exp_addr.size() > 0) begin
            ea = exp_addr.pop_front();
            total_cnt++;
            if (ba >= act_addr.size() || act_addr[ba] !== ea) $display("FAIL clamp_addr[%0d]: got %0d want %0d", ba, (ba < act_addr.size()) ? act_addr[ba] : 4'bx, ea); else pass_cnt++;
            ba++;
        end
    endtask

    task automatic test_abort;
        int bs, bd, bl, ba;
        bit ok;
        logic [NUM_LED-1:0] el;
        logic [3:0] ea;
        mem[0] = 1; mem[1] = 2; mem[2] = 3;
        bs = start_cnt; bd = done_cnt; bl = act_led.size(); ba = act_addr.size();
        push_step(0, 1);
        exp_led.push_back(4'b0100); exp_led.push_back(4'b0000);
        exp_addr.push_back(4'd1);
        do_play(3);
        wait_starts(bs + 3, 200, ok);
        total_cnt++; if (!ok || bus.led !== 4'b0100) $display("FAIL abort_reach_onwait: got led=%b want 0100", bus.led); else pass_cnt++;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        total_cnt++; if (bus.led !== 4'b0 || bus.busy !== 1'b0 || bus.start_timer !== 1'b0) $display("FAIL abort_idle: got led=%b busy=%b st=%b want 0000/0/0", bus.led, bus.busy, bus.start_timer); else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++; if (done_cnt !== bd || start_cnt !== bs + 3) $display("FAIL abort_quiet: got done=%0d starts=%0d want 0/3", done_cnt - bd, start_cnt - bs); else pass_cnt++;
        // abort together with play in IDLE: nothing starts
        @(negedge clk);
        bus.seq_len = 5'd2; bus.play = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.play = 1'b0; bus.abort = 1'b0;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL abort_beats_play: got busy=%b want 0", bus.busy); else pass_cnt++;
        push_step(0, 1);
        bd = done_cnt;
        do_play(1);
        wait_idle(200, bd, ok);
        total_cnt++; if (!ok) $display("FAIL abort_replay_timeout: got busy=%b want idle+done", bus.busy); else pass_cnt++;
        while (exp_led.size() > 0) begin
            el = exp_led.pop_front();
            total_cnt++;
            if (bl >= act_led.size() || act_led[bl] !== el) $display("FAIL abort_led[%0d]: got %b want %b", bl, (bl < act_led.size()) ? act_led[bl] : 4'bx, el); else pass_cnt++;
            bl++;
        end
        while (exp_addr.size() > 0) begin
            ea = exp_addr.pop_front();
            total_cnt++;
            if (ba >= act_addr.size() || act_addr[ba] !== ea) $display("FAIL abort_addr[%0d]: got %0d want %0d", ba, (ba < act_addr.size()) ? act_addr[ba] : 4'bx, ea); else pass_cnt++;
            ba++;
        end
    endtask

    task automatic test_back_to_back;
        int bs, bd, bl;
        bit ok;
        logic [NUM_LED-1:0] el;
        mem[0] = 3; mem[1] = 1; mem[2] = 2;
        bs = start_cnt; bd = done_cnt; bl = act_led.size();
        for (int i = 0; i < 3; i++) push_step(i, int'(mem[i]));
        do_play(3);
        wait_starts(bs + 2, 200, ok);
        do_play(1);
        wait_idle(500, bd, ok);
        total_cnt++; if (!ok) $display("FAIL b2b_timeout: got busy=%b want idle+done", bus.busy); else pass_cnt++;
        total_cnt++; if (start_cnt - bs !== 6) $display("FAIL b2b_starts: got %0d want 6", start_cnt - bs); else pass_cnt++;
        total_cnt++; if (done_cnt - bd !== 1) $display("FAIL b2b_done: got %0d want 1", done_cnt - bd); else pass_cnt++;
        exp_addr.delete();
        while (exp_led.size() > 0) begin
            el = exp_led.pop_front();
            total_cnt++;
            if (bl >= act_led.size() || act_led[bl] !== el) $display("FAIL b2b_led[%0d]: got %b want %b", bl, (bl < act_led.size()) ? act_led[bl] : 4'bx, el); else pass_cnt++;
            bl++;
        end
    endtask

    task automatic test_async_reset;
        int bs;
        bit ok;
        mem[0] = 0; mem[1] = 1;
        bs = start_cnt;
        do_play(2);
        wait_starts(bs + 2, 200, ok);
        total_cnt++; if (!ok || bus.busy !== 1'b1) $display("FAIL rst_reach_offwait: got busy=%b want 1", bus.busy); else pass_cnt++;
        #2 reset_n = 1'b0;
        #1;
        total_cnt++; if (bus.led !== 4'b0 || bus.busy !== 1'b0 || bus.start_timer !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL rst_async: got led=%b busy=%b st=%b done=%b want all 0", bus.led, bus.busy, bus.start_timer, bus.done); else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        bs = start_cnt;
        repeat (6) @(negedge clk);
        total_cnt++; if (bus.busy !== 1'b0 || start_cnt !== bs) $display("FAIL rst_stays_idle: got busy=%b starts=%0d want 0/0", bus.busy, start_cnt - bs); else pass_cnt++;
    endtask

    initial begin
        bus.play = 1'b0;
        bus.abort = 1'b0;
        bus.seq_len = '0;
        for (int i = 0; i < MAX_LEN; i++) mem[i] = '0;
        test_reset;
        test_basic;
        test_zero_len;
        test_clamp;
        test_abort;
        test_back_to_back;
        test_async_reset;
        total_cnt++; if (dbl_cnt !== 0) $display("FAIL start_double_final: got %0d want 0", dbl_cnt); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
